lc3_sequencer: RTL

Stage sequencer and instruction register for the LC3 core. It sits directly upstream of the control decoder and drives that decoder's `STAGE` and `IR` inputs. It steps each instruction through FETCH → DECODE → EXECUTE → WRITEBACK, stalls on memory wait states, halts on `TRAP x25`, and counts retired instructions. Datapath register load enables are ANDed with `STEP_EN`, so nothing updates while the core is idle, stalled or halted.

---
 rtl/lc3_sequencer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/lc3_sequencer.sv
// LC3 stage sequencer: steps instructions through FETCH/DECODE/EXECUTE/WRITEBACK, holds IR, counts retires.
// Macro LC3_MEM_WAIT_EN: when defined, MEM_READY stalls FETCH and LDR/STR WRITEBACK; otherwise memory is zero-wait.
module lc3_sequencer (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        RUN,
    input  logic        MEM_READY,
    input  logic [15:0] MEM_RDATA,
    output logic [1:0]  STAGE,
    output logic [15:0] IR,
    output logic        STEP_EN,
    output logic        BUSY,
    output logic        HALTED,
    output logic [15:0] RETIRE_CNT
);
    localparam int unsigned IR_W  = 16;
    localparam int unsigned CNT_W = 16;
    localparam logic [IR_W-1:0] TRAP_HALT = 16'hF025;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [1:0]         r_stage;
    logic [IR_W-1:0]    r_ir;
    logic               r_busy;
    logic               r_halted;
    logic [CNT_W-1:0]   r_retire_cnt;

    logic               w_mem_ok;
    logic               w_is_mem;
    logic               w_step_en;
    logic               w_load_ir;
    logic               w_retire;
    logic               w_next_busy;

`ifdef LC3_MEM_WAIT_EN
    assign w_mem_ok = MEM_READY;
`else
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = MEM_READY;
    assign w_mem_ok = 1'b1;
`endif

    // LDR (0110) and STR (0111) are the only opcodes that wait in WRITEBACK
    assign w_is_mem = (r_ir[15:13] == 3'b011);

    function automatic logic [1:0] stage_of(input state_t s);
        case (s)
            S_DECODE:    return 2'b00;
            S_EXECUTE:   return 2'b01;
            S_WRITEBACK: return 2'b10;
            default:     return 2'b11;
        endcase
    endfunction

    always_comb begin
        w_next_state = r_state;
        w_step_en    = 1'b0;
        w_load_ir    = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (RUN) w_next_state = S_FETCH;
            end
            S_FETCH: begin
                if (w_mem_ok) begin
                    w_step_en    = 1'b1;
                    w_load_ir    = 1'b1;
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                w_step_en    = 1'b1;
                w_next_state = (r_ir == TRAP_HALT) ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                w_step_en    = 1'b1;
                w_next_state = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                if (!w_is_mem || w_mem_ok) begin
                    w_step_en    = 1'b1;
                    w_retire     = 1'b1;
                    w_next_state = RUN ? S_FETCH : S_IDLE;
                end
            end
            S_HALT: begin
                if (!RUN) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_next_busy = (w_next_state == S_FETCH) || (w_next_state == S_DECODE) ||
                         (w_next_state == S_EXECUTE) || (w_next_state == S_WRITEBACK);

    // Status outputs are registered from the next state so they align with the state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= S_IDLE;
            r_stage      <= 2'b11;
            r_ir         <= '0;
            r_busy       <= 1'b0;
            r_halted     <= 1'b0;
            r_retire_cnt <= '0;
        end else begin
            r_state  <= w_next_state;
            r_stage  <= stage_of(w_next_state);
            r_busy   <= w_next_busy;
            r_halted <= (w_next_state == S_HALT);
            if (w_load_ir) r_ir <= MEM_RDATA;
            if (w_retire)  r_retire_cnt <= r_retire_cnt + CNT_W'(1);
        end
    end

    assign STAGE      = r_stage;
    assign IR         = r_ir;
    assign STEP_EN    = w_step_en;
    assign BUSY       = r_busy;
    assign HALTED     = r_halted;
    assign RETIRE_CNT = r_retire_cnt;

endmodule
